// File: rtl/pixel_tx_pkg.sv
// Shared types and constants for the pixel transmitter: FSM state encoding and pixel width.
package npu_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_BLANK,
    ST_DONE
  } pixel_tx_state_t;

  // A counter for 0..n-1 needs at least one bit even when n is 1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_tx_if.sv
// Source byte stream bundle: valid/data from the producer, ready from the buffer.
// Handshake: a byte moves on every rising clk edge where valid=1 and ready=1;
// data must be stable while valid=1, and ready never depends on valid.
interface pixel_tx_if;
  import npu_pkg::*;

  logic               valid;
  logic [PIXEL_W-1:0] data;
  logic               ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pixel_tx_fifo.sv
// Synchronous single-clock source buffer (pixel_fifo) with full/empty/count.
// DEPTH must be a power of two, at least 2.
module pixel_fifo
  import npu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  pixel_tx_if.slave              wr,
  input  logic                   i_pop,
  output logic [PIXEL_W-1:0]     o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [PIXEL_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;
  logic               r_ready_en;
  logic               w_push;
  logic               w_pop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rptr];
  // ready stays low through reset and rises on the first edge after release.
  assign wr.ready = r_ready_en && !o_full;
  assign w_push   = wr.valid && wr.ready;
  assign w_pop    = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr.data;
  end

endmodule

// File: rtl/pixel_tx.sv
// Frame transmitter: drains a source FIFO into WIDTH x HEIGHT lines with HBLANK idle cycles.
// Optional build macro PIXEL_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module pixel_tx
  import npu_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int HBLANK     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               src_valid,
  input  logic [PIXEL_W-1:0] src_data,
  output logic               src_ready,
  output logic               data_enable,
  output logic [PIXEL_W-1:0] data_in,
  output logic               line_start,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy,
  output logic               underrun
`ifdef PIXEL_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]        underrun_cnt
`endif
);

  localparam int CW   = clog2_min1(WIDTH);
  localparam int RW   = clog2_min1(HEIGHT);
  localparam int BW   = clog2_min1(HBLANK);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  pixel_tx_state_t    r_state;
  pixel_tx_state_t    w_state_nxt;
  logic [CW-1:0]      r_col;
  logic [CW-1:0]      w_col_nxt;
  logic [RW-1:0]      r_row;
  logic [RW-1:0]      w_row_nxt;
  logic [BW-1:0]      r_blank;
  logic [BW-1:0]      w_blank_nxt;
  logic               w_pop;
  logic               r_de;
  logic [PIXEL_W-1:0] r_data;
  logic               r_line_start;
  logic               r_frame_start;

  logic [PIXEL_W-1:0] w_fifo_data;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNTW-1:0]    w_fifo_count;

  pixel_tx_if w_src_if ();

  assign w_src_if.valid = src_valid;
  assign w_src_if.data  = src_data;
  assign src_ready      = w_src_if.ready;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (w_src_if),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_blank_nxt = r_blank;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // An empty FIFO simply stalls the line; col holds so no pixel is skipped.
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (r_col == CW'(WIDTH - 1)) begin
            w_col_nxt   = '0;
            w_blank_nxt = '0;
            w_state_nxt = ST_BLANK;
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end
      end
      ST_BLANK: begin
        if (r_blank == BW'(HBLANK - 1)) begin
          if (r_row == RW'(HEIGHT - 1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_row_nxt   = r_row + RW'(1);
            w_state_nxt = ST_ACTIVE;
          end
        end else begin
          w_blank_nxt = r_blank + BW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_row_nxt   = '0;
        w_col_nxt   = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_blank       <= '0;
      r_de          <= 1'b0;
      r_data        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_blank       <= w_blank_nxt;
      r_de          <= w_pop;
      r_line_start  <= w_pop && (r_col == '0);
      r_frame_start <= w_pop && (r_col == '0) && (r_row == '0);
      if (w_pop) r_data <= w_fifo_data;
    end
  end

  assign data_enable = r_de;
  assign data_in     = r_data;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_done  = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);
  assign underrun    = (r_state == ST_ACTIVE) && w_fifo_empty;

`ifdef PIXEL_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_underrun_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_underrun_cnt <= '0;
    end else if (underrun && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  a_ready_not_full: assert property (@(posedge clk) disable iff (!reset)
    !(w_src_if.ready && w_fifo_full));
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    w_fifo_count <= CNTW'(FIFO_DEPTH));
  a_col_bound: assert property (@(posedge clk) disable iff (!reset)
    r_col <= CW'(WIDTH - 1));

endmodule

// File: tb/tb_pixel_tx.sv
// Directed bench for pixel_tx (WIDTH=4, HEIGHT=2, HBLANK=2, FIFO_DEPTH=8) with a byte scoreboard.
module tb_pixel_tx;
  import npu_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int D  = 8;
  localparam int FRAME_CYC = H * (W + HB);

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       data_enable;
  logic [7:0] data_in;
  logic       line_start;
  logic       frame_start;
  logic       frame_done;
  logic       busy;
  logic       underrun;
`ifdef PIXEL_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  pixel_tx_if src_if ();

  pixel_tx #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .HBLANK     (HB),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_valid    (src_if.valid),
    .src_data     (src_if.data),
    .src_ready    (src_if.ready),
    .data_enable  (data_enable),
    .data_in      (data_in),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .busy         (busy),
    .underrun     (underrun)
`ifdef PIXEL_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int urun_seen = 0;
  int fd_seen = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: accepted source bytes in, emitted pixels out
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      out_cnt = 0;
    end else begin
      if (src_if.valid && src_if.ready) exp_q.push_back(src_if.data);
      if (underrun) urun_seen++;
      if (frame_done) begin
        fd_seen++;
        out_cnt = 0;
      end
      if (data_enable) begin
        if (exp_q.size() == 0) chk("pixel_without_source", data_enable, 1'b0);
        else chk("data_in", data_in, exp_q.pop_front());
        chk("line_start", line_start, (out_cnt % W) == 0);
        chk("frame_start", frame_start, out_cnt == 0);
        out_cnt++;
      end else begin
        chk("flags_without_pixel", {line_start, frame_start}, 2'b00);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    src_if.valid = 1'b1;
    src_if.data  = d;
    while (!src_if.ready && n < 50) begin
      step();
      n++;
    end
    chk("push_ready_timeout", n < 50, 1'b1);
    step();
    src_if.valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {data_enable, data_in, line_start, frame_start, frame_done, busy, underrun,
              src_if.ready}, 32'd0);
  endtask

  task automatic wait_frame_done(input int budget);
    int fd0 = fd_seen;
    int n = 0;
    while (fd_seen == fd0 && n < budget) begin
      step();
      n++;
    end
    chk("frame_done_timeout", fd_seen != fd0, 1'b1);
  endtask

  // Called one cycle after the start edge; walks the whole frame timeline.
  task automatic run_frame_check(input int restart_at, input bit ready_chk);
    int  fd0 = fd_seen;
    int  u0  = urun_seen;
    bit  de_exp;
    for (int c = 0; c <= FRAME_CYC + 1; c++) begin
      start = (c == restart_at);
      @(negedge clk);
      de_exp = (c >= 1) && (((c - 1) % (W + HB)) < W) && (((c - 1) / (W + HB)) < H);
      chk($sformatf("de_c%0d", c), data_enable, de_exp);
      chk($sformatf("frame_done_c%0d", c), frame_done, c == FRAME_CYC);
      chk($sformatf("busy_c%0d", c), busy, c <= FRAME_CYC);
      if (ready_chk && c < 2) chk($sformatf("src_ready_pop_c%0d", c), src_if.ready, c == 1);
      step();
    end
    start = 1'b0;
    chk("frame_done_count", fd_seen - fd0, 1);
    chk("no_underrun", urun_seen - u0, 0);
  endtask

  initial begin
    int fd0;
    src_if.valid = 1'b0;
    src_if.data  = '0;
    repeat (3) step();
    chk_outputs_zero("in_reset");
`ifdef PIXEL_TX_UNDERRUN_CNT_EN
    chk("underrun_cnt_reset", underrun_cnt, 16'd0);
`endif
    reset = 1'b1;
    chk("src_ready_at_release", src_if.ready, 1'b0);
    step();
    chk("src_ready_after_release", src_if.ready, 1'b1);

    // fill to full with 10 offered bytes, then a preloaded frame
    for (int i = 0; i < 10; i++) begin
      src_if.valid = 1'b1;
      src_if.data  = 8'(i);
      step();
    end
    src_if.valid = 1'b0;
    chk("src_ready_full", src_if.ready, 1'b0);
    chk("queued_bytes", exp_q.size(), D);
    pulse_start();
    run_frame_check(-1, 1'b1);
    chk("scoreboard_empty_1", exp_q.size(), 0);

    // start pulse while ACTIVE is ignored
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    pulse_start();
    run_frame_check(2, 1'b0);

    // byte 2 arrives three cycles late
    urun_seen = 0;
    push(8'h20);
    push(8'h21);
    pulse_start();
    repeat (4) step();
    for (int i = 2; i < 8; i++) push(8'h20 + 8'(i));
    wait_frame_done(200);
    chk("underrun_pulses", urun_seen, 3);
`ifdef PIXEL_TX_UNDERRUN_CNT_EN
    chk("underrun_cnt_3", underrun_cnt, 16'd3);
`endif
    chk("scoreboard_empty_2", exp_q.size(), 0);

    // reset at row 1 col 2, then a full frame whose start coincides with a push
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    pulse_start();
    repeat (8) step();
    chk("de_before_abort", data_enable, 1'b1);
    fd0 = fd_seen;
    reset = 1'b0;
    #1;
    chk_outputs_zero("mid_frame_reset");
    repeat (2) step();
    chk("no_frame_done_on_abort", fd_seen, fd0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
    src_if.valid = 1'b1;
    src_if.data  = 8'h47;
    start = 1'b1;
    step();
    src_if.valid = 1'b0;
    start = 1'b0;
    run_frame_check(-1, 1'b0);
    chk("scoreboard_empty_3", exp_q.size(), 0);

`ifdef PIXEL_TX_UNDERRUN_CNT_EN
    // long starvation saturates the counter; next start clears it
    pulse_start();
    repeat (70000) step();
    chk("underrun_cnt_sat", underrun_cnt, 16'hFFFF);
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    wait_frame_done(200);
    chk("underrun_cnt_hold", underrun_cnt, 16'hFFFF);
    pulse_start();
    chk("underrun_cnt_clear", underrun_cnt, 16'd0);
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    wait_frame_done(200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
